imem_port_arbiter: RTL and testbench

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

---
 rtl/imem_port_arbiter.sv | 117 +++++++++++
 tb/tb_imem_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: shares one single-port memory between the
// fetch unit and the program loader, with a bounded fetch burst and a loader lock.
module imem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_FETCH_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  output logic              f_rsp_err,
  input  logic              flush,
  input  logic              l_lock,
  input  logic              l_req_valid,
  input  logic [ADDR_W-1:0] l_req_addr,
  input  logic [DATA_W-1:0] l_req_data,
  output logic              l_req_ready,
  output logic              l_wr_done,
  output logic              l_err,
  output logic              mem_en,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] LOAD   = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  localparam logic [3:0] BURST_MAX = 4'(MAX_FETCH_BURST);

  logic [1:0]        state, state_nxt;
  logic [3:0]        burst_cnt, burst_nxt;
  logic              f_grant, l_grant, load_turn;
  logic              f_aligned, l_aligned;
  logic [DATA_W-1:0] f_data_q;
  logic              f_err_q, l_done_q, l_err_q;

  // Grants are gated by rst so the ready/memory outputs fall the moment reset asserts.
  always_comb begin
    f_grant   = 1'b0;
    l_grant   = 1'b0;
    load_turn = 1'b0;
    f_aligned = (f_req_addr[1:0] == 2'b00);
    l_aligned = (l_req_addr[1:0] == 2'b00);
    if (rst) begin
      if (l_lock) begin
        l_grant = l_req_valid;
      end else begin
        load_turn = l_req_valid && (burst_cnt == BURST_MAX);
        f_grant   = f_req_valid && !load_turn;
        l_grant   = l_req_valid && !f_grant;
      end
    end
  end

  always_comb begin
    if (l_lock)       state_nxt = LOCKED;
    else if (f_grant) state_nxt = FETCH;
    else if (l_grant) state_nxt = LOAD;
    else              state_nxt = IDLE;

    if (l_grant || !l_req_valid)
      burst_nxt = '0;
    else if (f_grant && (burst_cnt < BURST_MAX))
      burst_nxt = burst_cnt + 4'd1;
    else
      burst_nxt = burst_cnt;
  end

  always_comb begin
    f_req_ready    = f_grant;
    l_req_ready    = l_grant;
    mem_en         = (f_grant && f_aligned) || (l_grant && l_aligned);
    mem_rd_wr      = !(l_grant && l_aligned);
    mem_read_addr  = (f_grant && f_aligned) ? f_req_addr : '0;
    mem_write_addr = (l_grant && l_aligned) ? l_req_addr : '0;
    mem_write_data = (l_grant && l_aligned) ? l_req_data : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      f_data_q  <= '0;
      f_err_q   <= 1'b0;
      l_done_q  <= 1'b0;
      l_err_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      f_err_q   <= f_grant && !f_aligned;
      l_done_q  <= l_grant;
      l_err_q   <= l_grant && !l_aligned;
      if (f_grant)
        f_data_q <= f_aligned ? mem_read_data : '0;
    end
  end

  // state is registered from the grant cycle, so a lock raised during the
  // response cycle does not suppress an already-granted fetch response.
  always_comb begin
    f_rsp_valid = (state == FETCH) && !flush;
    f_rsp_err   = f_err_q && f_rsp_valid;
    f_rsp_data  = f_data_q;
    l_wr_done   = l_done_q;
    l_err       = l_err_q;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed, table-driven bench for imem_port_arbiter with a behavioural
// single-port memory attached to the mem_* port.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req_valid;
  logic [31:0] f_req_addr;
  logic        f_req_ready, f_rsp_valid, f_rsp_err;
  logic [31:0] f_rsp_data;
  logic        flush, l_lock, l_req_valid;
  logic [31:0] l_req_addr, l_req_data;
  logic        l_req_ready, l_wr_done, l_err;
  logic        mem_en, mem_rd_wr;
  logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

  logic [31:0] mem [0:255];
  logic        load_mem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_FETCH_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .flush(flush), .l_lock(l_lock),
    .l_req_valid(l_req_valid), .l_req_addr(l_req_addr), .l_req_data(l_req_data),
    .l_req_ready(l_req_ready), .l_wr_done(l_wr_done), .l_err(l_err),
    .mem_en(mem_en), .mem_rd_wr(mem_rd_wr),
    .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_read_addr[9:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[0] <= 32'h0050_0093;
      mem[1] <= 32'h00A0_0113;
      mem[2] <= 32'h0020_81B3;
    end else if (mem_en && !mem_rd_wr) begin
      mem[mem_write_addr[9:2]] <= mem_write_data;
    end
  end

  typedef struct {
    logic fv; logic [31:0] fa; logic lk; logic lv; logic [31:0] la; logic [31:0] ld; logic fl;
    logic fr; logic lr; logic en; logic rw; logic rv; logic re; logic [31:0] rd; logic wd; logic le;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] fa, input logic lk,
                       input logic lv, input logic [31:0] la, input logic [31:0] ld,
                       input logic fl);
    f_req_valid = fv; f_req_addr = fa; l_lock = lk;
    l_req_valid = lv; l_req_addr = la; l_req_data = ld; flush = fl;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " f_req_ready"}, 32'(f_req_ready), 32'd0);
    chk({tag, " l_req_ready"}, 32'(l_req_ready), 32'd0);
    chk({tag, " mem_en"},      32'(mem_en),      32'd0);
    chk({tag, " mem_rd_wr"},   32'(mem_rd_wr),   32'd1);
    chk({tag, " f_rsp_valid"}, 32'(f_rsp_valid), 32'd0);
    chk({tag, " f_rsp_err"},   32'(f_rsp_err),   32'd0);
    chk({tag, " f_rsp_data"},  f_rsp_data,       32'd0);
    chk({tag, " l_wr_done"},   32'(l_wr_done),   32'd0);
    chk({tag, " l_err"},       32'(l_err),       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Field order: fv fa lk lv la ld fl | fr lr en rw rv re rd wd le
    vq.push_back('{1,32'h00,0,0,0,0,0, 1,0,1,1,0,0,0,0,0});
    vq.push_back('{1,32'h04,0,0,0,0,0, 1,0,1,1,1,0,32'h0050_0093,0,0});
    vq.push_back('{1,32'h08,0,0,0,0,0, 1,0,1,1,1,0,32'h00A0_0113,0,0});
    vq.push_back('{0,32'h00,0,0,0,0,0, 0,0,0,1,1,0,32'h0020_81B3,0,0});
    vq.push_back('{0,32'h00,0,0,0,0,0, 0,0,0,1,0,0,0,0,0});
    vq.push_back('{0,32'h00,0,1,32'h10,32'hDEAD_BEEF,0, 0,1,1,0,0,0,0,0,0});
    vq.push_back('{1,32'h10,0,0,0,0,0, 1,0,1,1,0,0,0,1,0});
    vq.push_back('{0,32'h00,0,0,0,0,0, 0,0,0,1,1,0,32'hDEAD_BEEF,0,0});
    vq.push_back('{1,32'h06,0,0,0,0,0, 1,0,0,1,0,0,0,0,0});
    vq.push_back('{0,32'h00,0,1,32'h13,32'h1234_5678,0, 0,1,0,1,1,1,32'h0,0,0});
    vq.push_back('{0,32'h00,0,0,0,0,0, 0,0,0,1,0,0,0,1,1});
    vq.push_back('{1,32'h10,0,0,0,0,0, 1,0,1,1,0,0,0,0,0});
    vq.push_back('{0,32'h00,0,0,0,0,0, 0,0,0,1,1,0,32'hDEAD_BEEF,0,0});
    vq.push_back('{1,32'h20,0,0,0,0,0, 1,0,1,1,0,0,0,0,0});
    vq.push_back('{1,32'h40,0,0,0,0,1, 1,0,1,1,0,0,0,0,0});
    vq.push_back('{0,32'h00,0,0,0,0,0, 0,0,0,1,1,0,32'hA500_0010,0,0});
    // Contention: F,F,F,F,L twice
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (k == 0 && j == 0)
          vq.push_back('{1,32'h00,0,1,32'h100,32'h55,0, 1,0,1,1,0,0,0,0,0});
        else if (k == 1 && j == 0)
          vq.push_back('{1,32'h00,0,1,32'h100,32'h55,0, 1,0,1,1,0,0,0,1,0});
        else
          vq.push_back('{1,32'h00,0,1,32'h100,32'h55,0, 1,0,1,1,1,0,32'h0050_0093,0,0});
      end
      vq.push_back('{1,32'h00,0,1,32'h100,32'h55,0, 0,1,1,0,1,0,32'h0050_0093,0,0});
    end
    vq.push_back('{0,32'h00,0,0,0,0,0, 0,0,0,1,0,0,0,1,0});
    vq.push_back('{1,32'h100,0,0,0,0,0, 1,0,1,1,0,0,0,0,0});
    // Lock: fetch stalled, loads every cycle, then release with both pending
    vq.push_back('{1,32'h00,1,0,0,0,0, 0,0,0,1,1,0,32'h55,0,0});
    vq.push_back('{1,32'h00,1,1,32'h104,32'h66,0, 0,1,1,0,0,0,0,0,0});
    vq.push_back('{1,32'h00,1,1,32'h108,32'h77,0, 0,1,1,0,0,0,0,1,0});
    vq.push_back('{1,32'h00,0,1,32'h10C,32'h88,0, 1,0,1,1,0,0,0,1,0});
    vq.push_back('{0,32'h00,0,0,0,0,0, 0,0,0,1,1,0,32'h0050_0093,0,0});
    vq.push_back('{1,32'h104,0,0,0,0,0, 1,0,1,1,0,0,0,0,0});
    vq.push_back('{1,32'h108,0,0,0,0,0, 1,0,1,1,1,0,32'h66,0,0});
    vq.push_back('{0,32'h00,0,0,0,0,0, 0,0,0,1,1,0,32'h77,0,0});

    // Reset with both requesters active
    rst = 1'b0; load_mem = 1'b1;
    drive(1, 32'h0, 0, 1, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1 load_mem = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].fv, vq[i].fa, vq[i].lk, vq[i].lv, vq[i].la, vq[i].ld, vq[i].fl);
      @(negedge clk);
      chk($sformatf("row%0d f_req_ready", i), 32'(f_req_ready), 32'(vq[i].fr));
      chk($sformatf("row%0d l_req_ready", i), 32'(l_req_ready), 32'(vq[i].lr));
      chk($sformatf("row%0d mem_en", i),      32'(mem_en),      32'(vq[i].en));
      chk($sformatf("row%0d mem_rd_wr", i),   32'(mem_rd_wr),   32'(vq[i].rw));
      chk($sformatf("row%0d f_rsp_valid", i), 32'(f_rsp_valid), 32'(vq[i].rv));
      chk($sformatf("row%0d f_rsp_err", i),   32'(f_rsp_err),   32'(vq[i].re));
      chk($sformatf("row%0d l_wr_done", i),   32'(l_wr_done),   32'(vq[i].wd));
      chk($sformatf("row%0d l_err", i),       32'(l_err),       32'(vq[i].le));
      if (vq[i].rv)
        chk($sformatf("row%0d f_rsp_data", i), f_rsp_data, vq[i].rd);
      @(posedge clk); #1;
    end

    // Reset in the middle of a load: committed edge keeps its write, the next is dropped
    drive(0, 32'h0, 0, 1, 32'h200, 32'h99, 0);
    @(posedge clk); #1;
    drive(1, 32'h0, 0, 1, 32'h204, 32'hAA, 0);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midload");
    @(posedge clk); #1;
    chk("midload committed", mem[8'h80], 32'h99);
    chk("midload dropped",   mem[8'h81], 32'hA500_0081);
    rst = 1'b1;
    drive(1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("resume f_req_ready", 32'(f_req_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("resume f_rsp_valid", 32'(f_rsp_valid), 32'd1);
    chk("resume f_rsp_data",  f_rsp_data, 32'h0050_0093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
